// File: rtl/ram32_byte_host_pkg.sv
// Shared definitions for the byte-stream host of the 32x32 RAM macro:
// FSM state type, command byte field positions and counter sizing.
package ram32_byte_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_RD_SEND
    } state_t;

    // Command byte: [7]=WR, [6:5]=N (burst of N+1 words), [4:0]=start address
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_N_LSB    = 5;
    localparam int unsigned CMD_N_W      = 2;
    localparam int unsigned CMD_ADDR_LSB = 0;
    localparam int unsigned CMD_ADDR_W   = 5;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram32_byte_host.sv
// Byte-wide command/data stream to word-wide RAM macro initiator: assembles
// write words from bytes, issues single-cycle macro accesses, serialises reads.
module ram32_byte_host
    import ram32_byte_host_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LANES  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy,
    output logic                 ram_en,
    output logic [LANES-1:0]     ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [8*LANES-1:0]   ram_di,
    input  logic [8*LANES-1:0]   ram_do
);

    localparam int unsigned WORD_W = 8 * LANES;
    localparam int unsigned LANE_W = cnt_width(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t               state;
    logic [LANE_W-1:0]    lane;
    logic [CMD_N_W-1:0]   words_left;
    logic [WORD_W-1:0]    shreg;

    logic [WORD_W+7:0]    wr_cat;
    logic [WORD_W-1:0]    wr_word;
    logic [WORD_W-1:0]    rd_shift;
    logic                 in_fire;
    logic                 out_fire;

    // New byte enters at the top so the first byte of a word ends up in [7:0].
    always_comb begin
        wr_cat   = {in_data, shreg};
        wr_word  = wr_cat[WORD_W+7:8];
        rd_shift = shreg >> 8;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            lane       <= '0;
            words_left <= '0;
            shreg      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= '0;
            ram_addr   <= '0;
            ram_di     <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= '0;

            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        ram_addr   <= ADDR_W'(in_data[CMD_ADDR_LSB +: CMD_ADDR_W]);
                        words_left <= in_data[CMD_N_LSB +: CMD_N_W];
                        lane       <= '0;
                        busy       <= 1'b1;
                        if (in_data[CMD_WR_BIT]) begin
                            state <= ST_WDATA;
                        end else begin
                            in_ready <= 1'b0;
                            ram_en   <= 1'b1;
                            state    <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_WDATA: begin
                    if (in_fire) begin
                        shreg <= wr_word;
                        if (lane == LAST_LANE) begin
                            ram_di   <= wr_word;
                            ram_en   <= 1'b1;
                            ram_we   <= '1;
                            in_ready <= 1'b0;
                            lane     <= '0;
                            state    <= ST_WR_ISSUE;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end

                ST_WR_ISSUE: begin
                    in_ready <= 1'b1;
                    if (words_left != '0) begin
                        words_left <= words_left - CMD_N_W'(1);
                        ram_addr   <= ram_addr + ADDR_W'(1);
                        state      <= ST_WDATA;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                ST_RD_ISSUE: begin
                    state <= ST_RD_CAP;
                end

                // Macro output is only valid this one cycle; it reads as zero afterwards.
                ST_RD_CAP: begin
                    shreg     <= ram_do;
                    out_data  <= ram_do[7:0];
                    out_valid <= 1'b1;
                    lane      <= '0;
                    state     <= ST_RD_SEND;
                end

                ST_RD_SEND: begin
                    if (out_fire) begin
                        if (lane == LAST_LANE) begin
                            out_valid <= 1'b0;
                            lane      <= '0;
                            if (words_left != '0) begin
                                words_left <= words_left - CMD_N_W'(1);
                                ram_addr   <= ram_addr + ADDR_W'(1);
                                ram_en     <= 1'b1;
                                state      <= ST_RD_ISSUE;
                            end else begin
                                busy     <= 1'b0;
                                in_ready <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            shreg    <= rd_shift;
                            out_data <= rd_shift[7:0];
                            lane     <= lane + LANE_W'(1);
                        end
                    end
                end

                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram32_byte_host.sv
// Bench for ram32_byte_host with a behavioural model of the 32x32 RAM macro;
// expected writes and read bytes are queued at stimulus time and matched later.
module tb_ram32_byte_host;

    localparam int AW = 5;
    localparam int LN = 4;

    typedef struct {
        logic [AW-1:0]   a;
        logic [8*LN-1:0] d;
        logic [LN-1:0]   we;
        int              cyc;
    } wr_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_data = 8'h00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      out_data;
    logic            busy;
    logic            ram_en;
    logic [LN-1:0]   ram_we;
    logic [AW-1:0]   ram_addr;
    logic [8*LN-1:0] ram_di;
    logic [8*LN-1:0] ram_do;

    ram32_byte_host #(.ADDR_W(AW), .LANES(LN)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // RAM macro model: registered read-before-write, Do0 forced to 0 when EN0 low
    logic [8*LN-1:0] mem [32];
    logic [8*LN-1:0] wmerge;
    always_comb begin
        wmerge = mem[ram_addr];
        for (int unsigned l = 0; l < LN; l++)
            if (ram_we[l]) wmerge[8*l +: 8] = ram_di[8*l +: 8];
    end
    always @(posedge CLK) begin
        if (ram_en) begin
            ram_do        <= mem[ram_addr];
            mem[ram_addr] <= wmerge;
        end else begin
            ram_do <= '0;
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [8*LN-1:0] refmem [32];
    logic [7:0]      wbytes [$];
    wr_t             exp_writes [$];
    wr_t             obs_writes [$];
    logic [7:0]      exp_bytes [$];
    logic [7:0]      obs_bytes [$];
    int              en_cycles = 0;
    int              rise_cyc = -1;
    int              busy_gaps = 0;
    int              stall_errs = 0;
    bit              track_busy = 0;
    bit              prev_ov = 0;
    int              last_acc = 0;
    int              rd_acc = 0;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (ram_en) begin
                    en_cycles++;
                    if (ram_we != '0) obs_writes.push_back('{ram_addr, ram_di, ram_we, cyc});
                end
                if (out_valid && out_ready) obs_bytes.push_back(out_data);
                if (out_valid && !prev_ov) rise_cyc = cyc;
                prev_ov = out_valid;
                if (track_busy && !busy) busy_gaps++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        bit ok;
        g  = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        ok = 0;
        repeat (g) begin @(posedge CLK); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (in_ready) begin
                @(posedge CLK); #1;
                ok = 1;
                break;
            end
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        last_acc = cyc;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL in_handshake: in_ready stayed low, byte %h not accepted", b);
        end
    endtask

    task automatic issue_write(input logic [7:0] cmd, input int gap_max);
        logic [AW-1:0]   a;
        logic [8*LN-1:0] word;
        int              nw;
        a  = cmd[4:0];
        nw = int'(cmd[6:5]) + 1;
        send_byte(cmd, 0);
        track_busy = 1;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int l = 0; l < LN; l++) begin
                word[8*l +: 8] = wbytes[w*LN + l];
                send_byte(wbytes[w*LN + l], gap_max);
            end
            exp_writes.push_back('{a, word, {LN{1'b1}}, last_acc});
            refmem[a] = word;
            a = a + 1'b1;
        end
    endtask

    task automatic issue_read(input logic [7:0] cmd);
        logic [AW-1:0] a;
        int            nw;
        a  = cmd[4:0];
        nw = int'(cmd[6:5]) + 1;
        send_byte(cmd, 0);
        rd_acc = last_acc;
        for (int w = 0; w < nw; w++) begin
            for (int l = 0; l < LN; l++) exp_bytes.push_back(refmem[a][8*l +: 8]);
            a = a + 1'b1;
        end
    endtask

    task automatic wait_writes(input int k);
        for (int t = 0; t < 400; t++) begin
            @(posedge CLK); #1;
            if (obs_writes.size() >= k) break;
        end
        track_busy = 0;
    endtask

    task automatic wait_bytes(input int k, input int stall);
        int         scnt;
        logic [7:0] hold;
        scnt = 0;
        hold = 8'h00;
        for (int t = 0; t < 600; t++) begin
            @(posedge CLK); #1;
            if (obs_bytes.size() >= k) break;
            if (stall == 0) begin
                out_ready = 1'b1;
            end else begin
                if (out_ready) begin out_ready = 1'b0; scnt = 0; end
                if (!out_ready && out_valid) begin
                    if (scnt == 0) hold = out_data;
                    else if (out_data !== hold) stall_errs++;
                    scnt++;
                    if (scnt == stall) out_ready = 1'b1;
                end
            end
        end
        out_ready = 1'b1;
        repeat (8) begin @(posedge CLK); #1; end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1 RST = 1'b1;
        #2;
        checks++;
        if ({in_ready, out_valid, busy, ram_en, ram_we, ram_addr, ram_di, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b en=%b we=%h a=%h di=%h od=%h, want all 0",
                     in_ready, out_valid, busy, ram_en, ram_we, ram_addr, ram_di, out_data);
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_write_single;
        wr_t e, o;
        int  en0;
        en0 = en_cycles;
        wbytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        issue_write(8'h83, 0);
        wait_writes(1);
        checks++;
        if (en_cycles - en0 != 1) begin errors++; $display("FAIL wr1_en_cycles: got %0d want 1", en_cycles - en0); end
        checks++;
        if (refmem[3] !== 32'h11223344) begin errors++; $display("FAIL wr1_model: got %h want 11223344", refmem[3]); end
        while (exp_writes.size() > 0) begin
            e = exp_writes.pop_front();
            checks++;
            if (obs_writes.size() == 0) begin errors++; $display("FAIL wr1_missing: no write, want addr %h", e.a); continue; end
            o = obs_writes.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.we !== e.we || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL wr1_write: got a=%h d=%h we=%h cyc=%0d want a=%h d=%h we=%h cyc=%0d",
                         o.a, o.d, o.we, o.cyc, e.a, e.d, e.we, e.cyc);
            end
        end
    endtask

    task automatic test_read_single;
        logic [7:0] eb, ob;
        int         en0;
        en0 = en_cycles;
        out_ready = 1'b1;
        issue_read(8'h03);
        wait_bytes(4, 0);
        checks++;
        if (rise_cyc != rd_acc + 2) begin errors++; $display("FAIL rd1_latency: out_valid at %0d want %0d", rise_cyc, rd_acc + 2); end
        checks++;
        if (en_cycles - en0 != 1) begin errors++; $display("FAIL rd1_en_cycles: got %0d want 1", en_cycles - en0); end
        while (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            checks++;
            if (obs_bytes.size() == 0) begin errors++; $display("FAIL rd1_missing: want %h", eb); continue; end
            ob = obs_bytes.pop_front();
            if (ob !== eb) begin errors++; $display("FAIL rd1_byte: got %h want %h", ob, eb); end
        end
        checks++;
        if (obs_bytes.size() != 0) begin errors++; $display("FAIL rd1_extra: %0d extra bytes, want 0", obs_bytes.size()); obs_bytes.delete(); end
    endtask

    task automatic test_wrap_burst;
        wr_t        e, o;
        logic [7:0] eb, ob;
        wbytes.delete();
        for (int i = 0; i < 12; i++) wbytes.push_back(8'($urandom));
        issue_write(8'hDE, 0);
        wait_writes(3);
        while (exp_writes.size() > 0) begin
            e = exp_writes.pop_front();
            checks++;
            if (obs_writes.size() == 0) begin errors++; $display("FAIL wrap_missing: no write, want addr %h", e.a); continue; end
            o = obs_writes.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.we !== e.we || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL wrap_write: got a=%h d=%h we=%h cyc=%0d want a=%h d=%h we=%h cyc=%0d",
                         o.a, o.d, o.we, o.cyc, e.a, e.d, e.we, e.cyc);
            end
        end
        issue_read(8'h5E);
        wait_bytes(12, 0);
        while (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            checks++;
            if (obs_bytes.size() == 0) begin errors++; $display("FAIL wrap_rd_missing: want %h", eb); continue; end
            ob = obs_bytes.pop_front();
            if (ob !== eb) begin errors++; $display("FAIL wrap_rd_byte: got %h want %h", ob, eb); end
        end
        checks++;
        if (obs_bytes.size() != 0) begin errors++; $display("FAIL wrap_rd_extra: %0d extra bytes", obs_bytes.size()); obs_bytes.delete(); end
    endtask

    task automatic test_stall;
        logic [7:0] eb, ob;
        int         n;
        stall_errs = 0;
        out_ready  = 1'b0;
        issue_read(8'h03);
        wait_bytes(4, 6);
        checks++;
        if (stall_errs != 0) begin errors++; $display("FAIL stall_hold: out_data changed %0d times while stalled, want 0", stall_errs); end
        n = obs_bytes.size();
        checks++;
        if (n != 4) begin errors++; $display("FAIL stall_count: got %0d bytes want 4", n); end
        while (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            checks++;
            if (obs_bytes.size() == 0) begin errors++; $display("FAIL stall_missing: want %h", eb); continue; end
            ob = obs_bytes.pop_front();
            if (ob !== eb) begin errors++; $display("FAIL stall_byte: got %h want %h", ob, eb); end
        end
        obs_bytes.delete();
    endtask

    task automatic test_reset_midstream;
        wr_t        e, o;
        logic [7:0] eb, ob;
        int         en0;
        out_ready = 1'b0;
        issue_read(8'h03);
        for (int t = 0; t < 20; t++) begin
            @(posedge CLK); #1;
            if (out_valid) break;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_rd_setup: out_valid %b want 1", out_valid); end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, ram_en, ram_we, ram_addr, ram_di, out_data} !== '0) begin
            errors++;
            $display("FAIL rst_rd_outputs: got ov=%b busy=%b od=%h, want all 0", out_valid, busy, out_data);
        end
        @(posedge CLK); #1 RST = 1'b0;
        exp_bytes.delete();
        obs_bytes.delete();

        en0 = en_cycles;
        send_byte(8'h85, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, ram_en, ram_we, ram_di} !== '0) begin
            errors++;
            $display("FAIL rst_wr_outputs: got rdy=%b busy=%b en=%b we=%h di=%h, want all 0", in_ready, busy, ram_en, ram_we, ram_di);
        end
        @(posedge CLK); #1 RST = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        checks++;
        if (en_cycles != en0) begin errors++; $display("FAIL rst_wr_no_write: %0d macro accesses, want 0", en_cycles - en0); end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle: rdy=%b busy=%b want 1 0", in_ready, busy); end

        wbytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        issue_write(8'h85, 0);
        wait_writes(1);
        while (exp_writes.size() > 0) begin
            e = exp_writes.pop_front();
            checks++;
            if (obs_writes.size() == 0) begin errors++; $display("FAIL rst_rec_missing: no write, want addr %h", e.a); continue; end
            o = obs_writes.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.we !== e.we) begin
                errors++;
                $display("FAIL rst_rec_write: got a=%h d=%h we=%h want a=%h d=%h we=%h", o.a, o.d, o.we, e.a, e.d, e.we);
            end
        end
        issue_read(8'h05);
        wait_bytes(4, 0);
        while (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            checks++;
            if (obs_bytes.size() == 0) begin errors++; $display("FAIL rst_rec_rd_missing: want %h", eb); continue; end
            ob = obs_bytes.pop_front();
            if (ob !== eb) begin errors++; $display("FAIL rst_rec_rd_byte: got %h want %h", ob, eb); end
        end
        obs_bytes.delete();
    endtask

    task automatic test_gaps;
        wr_t        e, o;
        logic [7:0] eb, ob;
        busy_gaps = 0;
        wbytes.delete();
        for (int i = 0; i < 8; i++) wbytes.push_back(8'($urandom));
        issue_write(8'hA7, 4);
        wait_writes(2);
        checks++;
        if (busy_gaps != 0) begin errors++; $display("FAIL gap_busy: busy low %0d cycles inside burst, want 0", busy_gaps); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_end: got %b want 0", busy); end
        while (exp_writes.size() > 0) begin
            e = exp_writes.pop_front();
            checks++;
            if (obs_writes.size() == 0) begin errors++; $display("FAIL gap_missing: no write, want addr %h", e.a); continue; end
            o = obs_writes.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.we !== e.we || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL gap_write: got a=%h d=%h we=%h cyc=%0d want a=%h d=%h we=%h cyc=%0d",
                         o.a, o.d, o.we, o.cyc, e.a, e.d, e.we, e.cyc);
            end
        end
        issue_read(8'h27);
        wait_bytes(8, 0);
        while (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            checks++;
            if (obs_bytes.size() == 0) begin errors++; $display("FAIL gap_rd_missing: want %h", eb); continue; end
            ob = obs_bytes.pop_front();
            if (ob !== eb) begin errors++; $display("FAIL gap_rd_byte: got %h want %h", ob, eb); end
        end
        checks++;
        if (obs_bytes.size() != 0) begin errors++; $display("FAIL gap_rd_extra: %0d extra bytes", obs_bytes.size()); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) refmem[i] = '0;
        test_reset;
        test_write_single;
        test_read_single;
        test_wrap_burst;
        test_stall;
        test_reset_midstream;
        test_gaps;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
